// File: rtl/ctrl_pipe_de.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_de
// Decode-to-execute control pipeline register of the five-stage RISC-V core.
// Captures the decoded control word each cycle, holds it on StallE and
// replaces it with a bubble (all zeros) on FlushE. In execute it resolves the
// fetch redirect PCSrcE from the registered control, Funct3E and ALU flags.
//
// Optional feature (macro CTRL_PIPE_DE_BUBBLE_CNT_EN):
//   defined     -> BubbleCntE is a saturating count of flush edges since reset
//   not defined -> BubbleCntE is tied to zero and no counter flops exist
//
// Ports:
//   clk, rst_n            core clock, synchronous active-low reset
//   *D control inputs     decoded control word (RegWrite, ResultSrc, MemWrite,
//                         Jump, Branch, ALUControl, ALUSrc, Funct3, Valid)
//   StallE, FlushE        hold / bubble requests (flush wins)
//   ZeroE, LtE, LtuE      ALU comparison flags from the execute stage
//   *E control outputs    registered control word
//   PCSrcE                redirect fetch to branch/jump target (combinational)
//   BubbleCntE            bubbles inserted since reset
// ---------------------------------------------------------------------------
module ctrl_pipe_de #(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RegWriteD,
  input  logic [1:0]           ResultSrcD,
  input  logic                 MemWriteD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic                 ALUSrcD,
  input  logic [2:0]           Funct3D,
  input  logic                 ValidD,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  output logic                 RegWriteE,
  output logic [1:0]           ResultSrcE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic [2:0]           Funct3E,
  output logic                 ValidE,
  output logic                 PCSrcE,
  output logic [CNT_W-1:0]     BubbleCntE
);

  logic                 r_reg_write;
  logic [1:0]           r_result_src;
  logic                 r_mem_write;
  logic                 r_jump;
  logic                 r_branch;
  logic [ALUCTRL_W-1:0] r_alu_control;
  logic                 r_alu_src;
  logic [2:0]           r_funct3;
  logic                 r_valid;
  logic                 w_taken;

  // Branch condition decode; the reserved codes 010/011 never take.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
    logic t;
    case (f3)
      3'b000:  t = zero;
      3'b001:  t = ~zero;
      3'b100:  t = lt;
      3'b101:  t = ~lt;
      3'b110:  t = ltu;
      3'b111:  t = ~ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Control word register: reset and flush both load a bubble, flush beats stall.
  always_ff @(posedge clk) begin
    if (!rst_n || FlushE) begin
      r_reg_write   <= 1'b0;
      r_result_src  <= 2'b00;
      r_mem_write   <= 1'b0;
      r_jump        <= 1'b0;
      r_branch      <= 1'b0;
      r_alu_control <= '0;
      r_alu_src     <= 1'b0;
      r_funct3      <= 3'b000;
      r_valid       <= 1'b0;
    end else if (StallE) begin
      r_reg_write   <= r_reg_write;
      r_result_src  <= r_result_src;
      r_mem_write   <= r_mem_write;
      r_jump        <= r_jump;
      r_branch      <= r_branch;
      r_alu_control <= r_alu_control;
      r_alu_src     <= r_alu_src;
      r_funct3      <= r_funct3;
      r_valid       <= r_valid;
    end else begin
      r_reg_write   <= RegWriteD;
      r_result_src  <= ResultSrcD;
      r_mem_write   <= MemWriteD;
      r_jump        <= JumpD;
      r_branch      <= BranchD;
      r_alu_control <= ALUControlD;
      r_alu_src     <= ALUSrcD;
      r_funct3      <= Funct3D;
      r_valid       <= ValidD;
    end
  end

  // Redirect resolution: follows the live ALU flags in the same cycle, and a
  // bubble (ValidE = 0) can never redirect even if stale bits were left behind.
  always_comb begin
    w_taken = branch_taken(r_funct3, ZeroE, LtE, LtuE);
  end

  assign PCSrcE      = r_valid & (r_jump | (r_branch & w_taken));
  assign RegWriteE   = r_reg_write;
  assign ResultSrcE  = r_result_src;
  assign MemWriteE   = r_mem_write;
  assign JumpE       = r_jump;
  assign BranchE     = r_branch;
  assign ALUControlE = r_alu_control;
  assign ALUSrcE     = r_alu_src;
  assign Funct3E     = r_funct3;
  assign ValidE      = r_valid;

`ifdef CTRL_PIPE_DE_BUBBLE_CNT_EN
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating bubble counter: counts flush edges, holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (FlushE && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign BubbleCntE = r_bubble_cnt;
`else
  assign BubbleCntE = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_de.sv
// Scoreboard bench for ctrl_pipe_de. Each driven cycle pushes the expected
// registered control word and bubble count; after the edge they are popped
// and compared against the DUT, and PCSrcE is checked against a reference
// branch decode for the current flags.
module tb_ctrl_pipe_de;
  localparam int CW = 2;  // small counter so saturation is reachable

  logic clk = 1'b0;
  logic rst_n;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD, Funct3D;
  logic StallE, FlushE, ZeroE, LtE, LtuE;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, PCSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE, Funct3E;
  logic [CW-1:0] BubbleCntE;

  ctrl_pipe_de #(.ALUCTRL_W(3), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .Funct3D(Funct3D), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .Funct3E(Funct3E), .ValidE(ValidE),
    .PCSrcE(PCSrcE), .BubbleCntE(BubbleCntE)
  );

  always #5 clk = ~clk;

  // Word layout: {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch,
  //               ALUControl[2:0], ALUSrc, Funct3[2:0], Valid}
  logic [13:0]   exp_q[$];
  logic [CW-1:0] cnt_q[$];
  logic [13:0]   m_word;   // model of the registered word after the last edge
  logic [CW-1:0] m_cnt;    // model of the bubble counter
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic ref_pcsrc(input logic [13:0] w, input logic z, input logic lt, input logic ltu);
    logic [2:0] f3;
    logic t;
    f3 = w[3:1];
    t = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z :
        (f3 == 3'b100) ? lt : (f3 == 3'b101) ? !lt :
        (f3 == 3'b110) ? ltu : (f3 == 3'b111) ? !ltu : 1'b0;
    return w[0] & (w[9] | (w[8] & t));
  endfunction

  // Drive one cycle of inputs and push the expected post-edge state.
  task automatic drive(input logic [13:0] d, input logic stall, input logic flush, input logic rn);
    logic [13:0]   nw;
    logic [CW-1:0] nc;
    {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD, Funct3D, ValidD} = d;
    StallE = stall; FlushE = flush; rst_n = rn;
    if (!rn || flush) nw = 14'd0;
    else if (stall)   nw = m_word;
    else              nw = d;
`ifdef CTRL_PIPE_DE_BUBBLE_CNT_EN
    if (!rn) nc = '0;
    else if (flush && m_cnt != {CW{1'b1}}) nc = m_cnt + 1'b1;
    else nc = m_cnt;
`else
    nc = '0;
`endif
    exp_q.push_back(nw);
    cnt_q.push_back(nc);
  endtask

  // Advance one edge, pop expectations and compare.
  task automatic tick(input string tag);
    logic [13:0] got;
    @(posedge clk);
    #1;
    m_word = exp_q.pop_front();
    m_cnt  = cnt_q.pop_front();
    got = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, Funct3E, ValidE};
    check_val({tag, "_word"}, 32'(got), 32'(m_word));
    check_val({tag, "_cnt"}, 32'(BubbleCntE), 32'(m_cnt));
    check_val({tag, "_pcsrc"}, 32'(PCSrcE), 32'(ref_pcsrc(m_word, ZeroE, LtE, LtuE)));
  endtask

  // Change flags without an edge and check the combinational redirect.
  task automatic flags(input string tag, input logic z, input logic lt, input logic ltu);
    ZeroE = z; LtE = lt; LtuE = ltu;
    #1;
    check_val(tag, 32'(PCSrcE), 32'(ref_pcsrc(m_word, z, lt, ltu)));
  endtask

  localparam logic [13:0] W_LOAD = 14'b1_01_0_0_0_010_0_000_1;
  localparam logic [13:0] W_A    = 14'b1_10_1_0_0_101_1_000_1;
  localparam logic [13:0] W_B    = 14'b0_11_0_0_0_011_0_111_1;
  localparam logic [13:0] W_JMP  = 14'b1_00_0_1_0_000_0_000_1;
  localparam logic [13:0] W_JINV = 14'b1_00_0_1_0_000_0_000_0;

  initial begin
    logic [2:0]  f3s [8];
    logic [13:0] w;
    m_word = 14'd0; m_cnt = '0;
    ZeroE = 1'b1; LtE = 1'b1; LtuE = 1'b1;
    f3s = '{3'b001, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};

    // Reset with all inputs high
    #2;
    drive(14'h3FFF, 1'b1, 1'b1, 1'b0); tick("rst0");
    drive(14'h3FFF, 1'b0, 1'b0, 1'b0); tick("rst1");

    // Plain load: visible exactly one edge later
    drive(W_LOAD, 1'b0, 1'b0, 1'b1); tick("load");

    // Load A, stall 3 cycles with B on D, then release
    drive(W_A, 1'b0, 1'b0, 1'b1); tick("loadA");
    for (int i = 0; i < 3; i++) begin
      drive(W_B, 1'b1, 1'b0, 1'b1); tick("stallA");
    end
    drive(W_B, 1'b0, 1'b0, 1'b1); tick("releaseB");

    // Stall and flush together -> bubble
    drive(W_A, 1'b1, 1'b1, 1'b1); tick("stallflush");

    // Branch resolution across all condition codes and flag patterns
    foreach (f3s[k]) begin
      w = 14'b0_00_0_0_1_000_0_000_1;
      w[3:1] = f3s[k];
      drive(w, 1'b0, 1'b0, 1'b1); tick("brload");
      for (int f = 0; f < 8; f++) flags("branch", f[0], f[1], f[2]);
    end

    // Jump redirect, then flush masks it even with stale flags
    drive(W_JMP, 1'b0, 1'b0, 1'b1); tick("jump");
    check_val("jump_pcsrc_one", 32'(PCSrcE), 32'd1);
    ZeroE = 1'b1;
    drive(W_JMP, 1'b0, 1'b1, 1'b1); tick("jumpflush");
    check_val("flush_pcsrc_zero", 32'(PCSrcE), 32'd0);
    drive(W_JINV, 1'b0, 1'b0, 1'b1); tick("jumpinvalid");
    check_val("invalid_pcsrc_zero", 32'(PCSrcE), 32'd0);

    // Reset mid-stall
    drive(W_A, 1'b0, 1'b0, 1'b1); tick("preA");
    drive(W_B, 1'b1, 1'b0, 1'b0); tick("rst_stall");

    // Counter: 5 flush edges, then stall-only edges
    for (int i = 0; i < 5; i++) begin
      drive(W_A, 1'b0, 1'b1, 1'b1); tick("cntflush");
    end
    for (int i = 0; i < 3; i++) begin
      drive(W_B, 1'b1, 1'b0, 1'b1); tick("cntstall");
    end
    // Reset mid-flush clears the counter
    drive(W_A, 1'b0, 1'b1, 1'b0); tick("rst_flush");
    drive(W_A, 1'b0, 1'b1, 1'b1); tick("cntafter");

    // Random mix of loads, stalls, flushes, resets and flags
    for (int i = 0; i < 60; i++) begin
      ZeroE = 1'($urandom); LtE = 1'($urandom); LtuE = 1'($urandom);
      drive(14'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 15) != 0));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
